// File: rtl/iq_sample_player_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iq_player_pkg : register map, bit indices and midscale helper
// Revision 1.0
// ----------------------------------------------------------------------------
package iq_player_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RATE   = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_FLUSH    = 1;

    localparam int STAT_FULL     = 0;
    localparam int STAT_UNDERRUN = 1;
    localparam int STAT_OVERFLOW = 2;

    localparam int DATA_I_LSB    = 16;
    localparam int DATA_Q_LSB    = 0;

    // Offset-binary zero: only the MSB set.
    function automatic logic [31:0] midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_sample_player_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iq_sample_player_if : pipelined Wishbone slave port bundle
// Revision 1.0
// ----------------------------------------------------------------------------
interface iq_sample_player_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [1:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );
endinterface
`default_nettype wire

// File: rtl/iq_sample_player_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo : single-clock first-word-fall-through FIFO with fill count
// Revision 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int AW    = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Count never exceeds DEPTH, so its MSB alone signals full.
    assign full_o  = count_q[AW];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/iq_sample_player.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iq_sample_player : Wishbone-fed I/Q FIFO paced onto two DAC channels
// Revision 1.0
// ----------------------------------------------------------------------------
module iq_sample_player
    import iq_player_pkg::*;
#(
    parameter int DAC_WIDTH = 10,
    parameter int FIFO_AW   = 9
) (
    input  logic                 i_clk,
    input  logic                 i_resetb,
    iq_sample_player_if.slave    wb,
    output logic [DAC_WIDTH-1:0] o_dac_a,
    output logic [DAC_WIDTH-1:0] o_dac_b,
    output logic                 o_sample_stb
);
    localparam logic [DAC_WIDTH-1:0] MID = DAC_WIDTH'(midscale(DAC_WIDTH));

    logic                   ack_q, ack_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   enable_q, enable_d;
    logic [15:0]            div_q, div_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   underrun_q, underrun_d;
    logic                   overflow_q, overflow_d;
    logic [DAC_WIDTH-1:0]   dac_a_q, dac_a_d, dac_b_q, dac_b_d;
    logic                   stb_q, stb_d;

    logic                   wr, rd, wr_ctrl, wr_rate, wr_data, wr_status;
    logic                   flush, tick;
    logic [2*DAC_WIDTH-1:0] fifo_wdata, fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic [FIFO_AW:0]       fifo_count;
    logic [31:0]            status;
    logic                   unused_wb_data;

    assign unused_wb_data = ^wb.i_wb_data;

    assign wr        = wb.i_wb_cyc && wb.i_wb_stb && wb.i_wb_we;
    assign rd        = wb.i_wb_cyc && wb.i_wb_stb && !wb.i_wb_we;
    assign wr_ctrl   = wr && (wb.i_wb_addr == ADDR_CTRL);
    assign wr_rate   = wr && (wb.i_wb_addr == ADDR_RATE);
    assign wr_data   = wr && (wb.i_wb_addr == ADDR_DATA);
    assign wr_status = wr && (wb.i_wb_addr == ADDR_STATUS);
    assign flush     = wr_ctrl && wb.i_wb_data[CTRL_FLUSH];

    // A counter reload (flush or RATE write) pre-empts any tick that cycle.
    assign tick = enable_q && (cnt_q == '0) && !flush && !wr_rate;

    assign fifo_wdata = {wb.i_wb_data[DATA_I_LSB +: DAC_WIDTH],
                         wb.i_wb_data[DATA_Q_LSB +: DAC_WIDTH]};

    sync_fifo #(
        .WIDTH (2*DAC_WIDTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_resetb),
        .flush_i (flush),
        .push_i  (wr_data),
        .pop_i   (tick),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status                = '0;
        status[31:16]         = 16'(fifo_count);
        status[STAT_OVERFLOW] = overflow_q;
        status[STAT_UNDERRUN] = underrun_q;
        status[STAT_FULL]     = fifo_full;
    end

    always_comb begin
        ack_d   = wb.i_wb_cyc && wb.i_wb_stb;
        rdata_d = '0;
        if (rd) begin
            case (wb.i_wb_addr)
                ADDR_CTRL:   rdata_d[CTRL_ENABLE] = enable_q;
                ADDR_RATE:   rdata_d[15:0]        = div_q;
                ADDR_STATUS: rdata_d              = status;
                default:     rdata_d              = '0;
            endcase
        end

        enable_d = wr_ctrl ? wb.i_wb_data[CTRL_ENABLE] : enable_q;
        div_d    = wr_rate ? wb.i_wb_data[15:0] : div_q;

        if (flush)                          cnt_d = div_q;
        else if (wr_rate)                   cnt_d = wb.i_wb_data[15:0];
        else if (!enable_q || cnt_q == '0)  cnt_d = div_q;
        else                                cnt_d = cnt_q - 16'd1;

        // Setting wins over a simultaneous software clear.
        underrun_d = underrun_q;
        if (wr_status && wb.i_wb_data[STAT_UNDERRUN]) underrun_d = 1'b0;
        if (tick && fifo_empty)                       underrun_d = 1'b1;

        overflow_d = overflow_q;
        if (wr_status && wb.i_wb_data[STAT_OVERFLOW]) overflow_d = 1'b0;
        if (wr_data && fifo_full && !flush)           overflow_d = 1'b1;

        stb_d   = 1'b0;
        dac_a_d = dac_a_q;
        dac_b_d = dac_b_q;
        if (flush || !enable_q) begin
            dac_a_d = MID;
            dac_b_d = MID;
        end else if (tick) begin
            if (!fifo_empty) begin
                dac_a_d = fifo_rdata[DAC_WIDTH +: DAC_WIDTH];
                dac_b_d = fifo_rdata[0 +: DAC_WIDTH];
                stb_d   = 1'b1;
            end else begin
                dac_a_d = MID;
                dac_b_d = MID;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            enable_q   <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            dac_a_q    <= MID;
            dac_b_q    <= MID;
            stb_q      <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            enable_q   <= enable_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            dac_a_q    <= dac_a_d;
            dac_b_q    <= dac_b_d;
            stb_q      <= stb_d;
        end
    end

    assign wb.o_wb_ack   = ack_q;
    assign wb.o_wb_stall = 1'b0;
    assign wb.o_wb_data  = rdata_q;
    assign o_dac_a       = dac_a_q;
    assign o_dac_b       = dac_b_q;
    assign o_sample_stb  = stb_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_sample_player.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_iq_sample_player : scoreboard bench for the I/Q sample player
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_iq_sample_player;

    localparam logic [1:0] A_CTRL = 2'd0, A_RATE = 2'd1, A_DATA = 2'd2, A_STAT = 2'd3;
    localparam logic [31:0] MID = 32'h200;

    logic       clk;
    logic       resetb;
    logic [9:0] dac_a, dac_b;
    logic       sample_stb;

    iq_sample_player_if wb_if ();

    iq_sample_player #(
        .DAC_WIDTH (10),
        .FIFO_AW   (9)
    ) dut (
        .i_clk        (clk),
        .i_resetb     (resetb),
        .wb           (wb_if),
        .o_dac_a      (dac_a),
        .o_dac_b      (dac_b),
        .o_sample_stb (sample_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [19:0] sb [$];
    logic [19:0] mon_exp;
    int          cyc_n    = 0;
    int          last_stb = -1;
    bit          pace_on  = 0;
    logic [31:0] rd_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wb_if.i_wb_cyc = 1; wb_if.i_wb_stb = 1; wb_if.i_wb_we = 1;
        wb_if.i_wb_addr = a; wb_if.i_wb_data = d;
        @(posedge clk); #1;
        chk("wr_ack", {31'd0, wb_if.o_wb_ack}, 1);
        wb_if.i_wb_cyc = 0; wb_if.i_wb_stb = 0; wb_if.i_wb_we = 0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        wb_if.i_wb_cyc = 1; wb_if.i_wb_stb = 1; wb_if.i_wb_we = 0; wb_if.i_wb_addr = a;
        @(posedge clk); #1;
        chk("rd_ack", {31'd0, wb_if.o_wb_ack}, 1);
        d = wb_if.o_wb_data;
        wb_if.i_wb_cyc = 0; wb_if.i_wb_stb = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_read(a, v);
        chk(tag, v, exp);
    endtask

    // Write one I/Q pair; scoreboard it only if the FIFO should accept it.
    task automatic push_pair(input logic [9:0] i_s, input logic [9:0] q_s, input bit accept);
        if (accept) sb.push_back({i_s, q_s});
        wb_write(A_DATA, {6'd0, i_s, 6'd0, q_s});
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_mid(input string tag);
        chk(tag, {22'd0, dac_a}, MID);
        chk(tag, {22'd0, dac_b}, MID);
    endtask

    always @(posedge clk) begin
        #1;
        cyc_n++;
        if (sample_stb) begin
            if (sb.size() == 0) begin
                chk("unexpected_stb", 1, 0);
            end else begin
                mon_exp = sb.pop_front();
                chk("dac_a", {22'd0, dac_a}, {22'd0, mon_exp[19:10]});
                chk("dac_b", {22'd0, dac_b}, {22'd0, mon_exp[9:0]});
            end
            if (pace_on && last_stb >= 0) chk("pace", cyc_n - last_stb, 4);
            last_stb = cyc_n;
        end
    end

    initial begin
        resetb = 0;
        wb_if.i_wb_cyc = 0; wb_if.i_wb_stb = 0; wb_if.i_wb_we = 0;
        wb_if.i_wb_addr = '0; wb_if.i_wb_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_mid("rst_dac");
        chk("rst_stb", {31'd0, sample_stb}, 0);
        chk("rst_ack", {31'd0, wb_if.o_wb_ack}, 0);
        chk("rst_rdata", wb_if.o_wb_data, 0);
        resetb = 1;

        // Readback of all registers after reset
        rd_chk("ctrl0", A_CTRL, 0);
        rd_chk("rate0", A_RATE, 0);
        rd_chk("data0", A_DATA, 0);
        rd_chk("stat0", A_STAT, 0);

        // Rate pacing at DIV=3
        wb_write(A_RATE, 32'd3);
        push_pair(10'h123, 10'h045, 1);
        push_pair(10'h3FF, 10'h000, 1);
        rd_chk("stat_fill2", A_STAT, 32'h0002_0000);
        pace_on = 1; last_stb = -1;
        wb_write(A_CTRL, 32'd1);
        wait_drain(40);
        pace_on = 0;
        repeat (6) @(posedge clk);
        #1;
        chk_mid("pace_underrun_dac");
        rd_chk("ctrl1", A_CTRL, 1);
        rd_chk("rate3", A_RATE, 3);
        rd_chk("stat_ur", A_STAT, 32'h2);
        wb_write(A_CTRL, 0);
        wb_write(A_STAT, 32'h2);
        rd_chk("stat_ur_clr", A_STAT, 0);

        // Underrun at full rate with an empty FIFO
        wb_write(A_RATE, 0);
        wb_write(A_CTRL, 1);
        repeat (3) @(posedge clk);
        #1;
        chk_mid("ur_dac");
        rd_chk("ur_set", A_STAT, 32'h2);
        wb_write(A_CTRL, 0);
        wb_write(A_STAT, 32'h2);
        rd_chk("ur_clr", A_STAT, 0);

        // Overflow: 513 writes while disabled, last one dropped
        for (int i = 0; i < 513; i++)
            push_pair(10'(i * 7 + 1), 10'(1023 - i), i < 512);
        rd_chk("ovf_full", A_STAT, 32'h0200_0005);
        wb_write(A_STAT, 32'h4);
        rd_chk("ovf_clr", A_STAT, 32'h0200_0001);

        // ENABLE then a push on the very tick cycle while full
        @(posedge clk); #1;
        wb_if.i_wb_cyc = 1; wb_if.i_wb_stb = 1; wb_if.i_wb_we = 1;
        wb_if.i_wb_addr = A_CTRL; wb_if.i_wb_data = 32'd1;
        @(posedge clk); #1;
        chk("b2b_ack0", {31'd0, wb_if.o_wb_ack}, 1);
        wb_if.i_wb_addr = A_DATA; wb_if.i_wb_data = 32'h02AA_0155;
        @(posedge clk); #1;
        chk("b2b_ack1", {31'd0, wb_if.o_wb_ack}, 1);
        wb_if.i_wb_cyc = 0; wb_if.i_wb_stb = 0; wb_if.i_wb_we = 0;
        wait_drain(600);
        repeat (3) @(posedge clk);
        #1;
        chk_mid("drained_dac");
        rd_chk("tick_ovf", A_STAT, 32'h6);
        wb_write(A_CTRL, 0);
        wb_write(A_STAT, 32'h6);
        rd_chk("flags_clr", A_STAT, 0);

        // Flush during playback
        wb_write(A_RATE, 32'd5);
        push_pair(10'h111, 10'h222, 1);
        push_pair(10'h0F0, 10'h30F, 1);
        push_pair(10'h1AA, 10'h055, 1);
        push_pair(10'h2CC, 10'h133, 1);
        wb_write(A_CTRL, 32'd1);
        begin
            int n = 0;
            while (sb.size() > 3 && n < 40) begin @(posedge clk); #2; n++; end
        end
        chk("flush_first", sb.size(), 3);
        wb_write(A_CTRL, 32'h3);
        sb.delete();
        chk_mid("flush_dac");
        wb_read(A_STAT, rd_val);
        chk("flush_cnt", rd_val >> 16, 0);
        repeat (10) @(posedge clk);
        wb_write(A_CTRL, 0);
        wb_write(A_STAT, 32'h6);

        // Asynchronous reset mid-stream
        wb_write(A_RATE, 32'd2);
        push_pair(10'h155, 10'h2AA, 1);
        push_pair(10'h0AB, 10'h3CD, 1);
        push_pair(10'h1EF, 10'h012, 1);
        wb_write(A_CTRL, 32'd1);
        begin
            int n = 0;
            while (sb.size() > 2 && n < 40) begin @(posedge clk); #2; n++; end
        end
        @(posedge clk); #3;
        chk("pre_rst_dac_a", {22'd0, dac_a}, 32'h155);
        resetb = 0;
        #1;
        chk_mid("async_rst_dac");
        chk("async_rst_stb", {31'd0, sample_stb}, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        resetb = 1;
        rd_chk("post_rst_ctrl", A_CTRL, 0);
        rd_chk("post_rst_rate", A_RATE, 0);
        rd_chk("post_rst_stat", A_STAT, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iq_sample_player.md
# iq_sample_player

Wishbone-programmable I/Q baseband sample player. It sits on the hbbus Wishbone fabric beside the FM generator slave and directly drives the two DAC channels. The host streams packed I/Q words into an on-chip FIFO, and the block pops one sample pair every RATE+1 clocks onto `o_dac_a` (I) and `o_dac_b` (Q). Underrun and overflow are reported through a status register.

## Interface
Parameters:
- `DAC_WIDTH`, 10: width of each DAC output; offset-binary coding.
- `FIFO_AW`, 9: FIFO address width; depth is 2^FIFO_AW = 512 entries.

Ports:
- `i_clk`, in, 1: system clock; all logic is on its rising edge.
- `i_resetb`, in, 1: reset, asynchronous and active-low.
- `i_wb_cyc`, in, 1: Wishbone cycle.
- `i_wb_stb`, in, 1: Wishbone strobe, already qualified by the page select.
- `i_wb_we`, in, 1: write enable.
- `i_wb_addr`, in, 2: register select.
- `i_wb_data`, in, 32: write data.
- `o_wb_ack`, out, 1: acknowledge.
- `o_wb_stall`, out, 1: tied to 0.
- `o_wb_data`, out, 32: read data.
- `o_dac_a`, out, DAC_WIDTH: I sample.
- `o_dac_b`, out, DAC_WIDTH: Q sample.
- `o_sample_stb`, out, 1: one-cycle pulse when a new pair is presented.

## Operation
Register map, selected by `i_wb_addr`:
- 0 CTRL (R/W):
  - bit0 ENABLE.
  - bit1 FLUSH: write-only, self-clearing, reads 0.
- 1 RATE (R/W): bits[15:0] DIV; one pop every DIV+1 clocks.
- 2 DATA (W): bits[25:16] = I, bits[9:0] = Q. Unused bits are ignored. Reads return 0.
- 3 STATUS:
  - Read: [31:16] fill count, [2] overflow (sticky), [1] underrun (sticky), [0] full.
  - Write: 1 to bit1 clears underrun; 1 to bit2 clears overflow.

FIFO behaviour:
- Every DATA write pushes one entry.
- A push while full is dropped and sets overflow. The full test uses the pre-pop count, so a push is dropped even when a pop happens in the same cycle.

Rate counter:
- Counts down while ENABLE=1. On reaching 0 it reloads DIV and issues a tick.
- While ENABLE=0 it holds at DIV.
- Writing RATE reloads the counter immediately.

Tick handling:
- FIFO non-empty: pop the head, register it onto the DAC outputs, pulse `o_sample_stb`.
- FIFO empty: set underrun and drive midscale on both outputs. `o_sample_stb` stays low.

Midscale is 1 << (DAC_WIDTH-1), i.e. 10'h200 at the default width.

ENABLE cleared: outputs return to midscale on the next clock; FIFO contents are retained.

FLUSH: empties the FIFO, reloads the counter, and drives midscale. The sticky flags are unchanged. If FLUSH coincides with a DATA write, the flush takes priority and the push is discarded.

## Timing
- Wishbone:
  - `o_wb_ack` = registered `i_wb_stb`, so exactly one cycle of latency, including single-cycle strobes and back-to-back strobes.
  - `o_wb_data` is valid in the ack cycle; it is 0 when not acking.
  - Writes take effect on the strobe edge.
- Push-to-availability: an entry written at edge N can be popped by a tick at edge N+1 or later.
- Tick to output: the DAC outputs and `o_sample_stb` update on the edge after the tick cycle.
- Pop period: with DIV=0, one pop per clock (full rate).
- Reset values:
  - `o_wb_ack` = 0, `o_wb_data` = 0.
  - `o_dac_a` = `o_dac_b` = midscale, `o_sample_stb` = 0.
  - ENABLE = 0, DIV = 0, FIFO empty, flags = 0.
- Reset asserted mid-stream: all state returns to the reset values asynchronously. Samples in flight are lost.

## Structure
- Package `iq_player_pkg` holds:
  - register address localparams (CTRL/RATE/DATA/STATUS);
  - CTRL/STATUS bit indices;
  - the midscale function of DAC_WIDTH.
- Sub-module `sync_fifo`: width 2*DAC_WIDTH, depth 2^FIFO_AW.
  - Provides push, pop, full, empty and count outputs (FIFO_AW+1 bits).
  - First-word-fall-through read data.
- The top level contains the Wishbone decode, rate counter and output registers.

## Test plan
- **Reset/readback:** release reset, read 0–3 -> ack one cycle after each strobe. CTRL=0, RATE=0, STATUS=0. DAC outputs = 10'h200.
- **Rate pacing:** write RATE=3 and DATA 0x01230045 and 0x03FF0000, then ENABLE=1.
  - Outputs 0x123/0x045, then 0x3FF/0x000.
  - `o_sample_stb` pulses exactly 4 clocks apart.
- **Underrun:** ENABLE with an empty FIFO, DIV=0 -> STATUS bit1=1, outputs 10'h200, no strobe. Writing STATUS 0x2 clears it.
- **Overflow:** 513 DATA writes with ENABLE=0 -> count=512, full=1, overflow=1. The 513th value is never output.
- **Flush and simultaneous events:**
  - FLUSH during playback -> count 0 next cycle, outputs midscale.
  - At full with ENABLE, DIV=0, a push on the tick cycle is dropped and overflow is set.
- **Async reset mid-stream:** assert `i_resetb`=0 between clock edges during playback -> outputs midscale immediately. After release, the FIFO is empty and CTRL=0.
